// File: rtl/msg_scroller_pkg.sv
// Shared types and constants for the message scroller: state encoding,
// character code width, blank code and the message glyph table.
package msg_scroller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCROLL = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  localparam int          CODE_W       = 4;
  localparam int          NUM_DIGITS   = 8;
  localparam logic [3:0]  BLANK_CODE   = 4'hF;
  localparam int          MSG_BASE_LEN = 8;

  // MSG[0] is the first character to enter from the right.
  localparam logic [3:0] MSG [0:MSG_BASE_LEN-1] = '{
    4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0
  };

  // Message glyph at index idx; longer messages repeat the base table.
  function automatic logic [3:0] msg_char(input int idx);
    logic [2:0] sel;
    sel = 3'(idx % MSG_BASE_LEN);
    return MSG[sel];
  endfunction

endpackage

// File: rtl/msg_scroller_if.sv
// Control and display bundle between the button/control side (master)
// and the scroller (slave).
interface msg_scroller_if;
  logic        start;
  logic        hold;
  logic        stop;
  logic [31:0] digits;
  logic        frame_upd;
  logic        busy;

  modport master (
    output start, hold, stop,
    input  digits, frame_upd, busy
  );

  modport slave (
    input  start, hold, stop,
    output digits, frame_upd, busy
  );
endinterface

// File: rtl/msg_scroller_tick_gen.sv
// Prescaler: counts 0..DIV-1 while enabled and flags the terminal count.
// clr forces the count back to zero; a disabled counter keeps its value.
module msg_scroller_tick_gen #(
  parameter logic [31:0] DIV = 32'd25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam logic [31:0] LAST = DIV - 32'd1;

  logic [31:0] cnt;

  assign tick = en && (cnt == LAST);

  // Count while enabled, wrap on terminal count, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 32'd1;
    end
  end
endmodule

// File: rtl/msg_scroller.sv
// Message scroller: feeds eight 4-bit character codes to the seven-segment
// driver, scrolling a fixed message right-to-left at TICK_DIV clocks/step.
// Optional macro SCROLL_HOLD_BLINK_EN makes the frozen frame blink in HOLD.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | display blank, prescaler cleared, waiting for start
// ST_SCROLL | prescaler running, pos advances on each tick
// ST_HOLD   | frame frozen, prescaler holds its count
module msg_scroller
  import msg_scroller_pkg::*;
#(
  parameter logic [31:0] TICK_DIV = 32'd25_000_000,
  parameter int          MSG_LEN  = 8
) (
  input logic          clk,
  input logic          rst,
  msg_scroller_if.slave bus
);
  localparam int L     = MSG_LEN + 8;
  localparam int POS_W = $clog2(L);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(L - 1);

  state_t           state, state_nxt;
  logic [POS_W-1:0] pos, pos_nxt;
  logic [31:0]      digits;
  logic             frame_upd;
  logic             upd;
  logic             blank_sel;
  logic             cnt_en, cnt_clr;
  logic             tick;

  // Frame for position p: digit k shows stream entry (p + 7 - k) mod L,
  // where the first eight stream entries are blanks.
  function automatic logic [31:0] frame_at(input logic [POS_W-1:0] p);
    logic [31:0] f;
    int          idx;
    f = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      idx = int'(p) + 7 - k;
      if (idx >= L) idx = idx - L;
      if (idx >= 8) f[k*CODE_W +: CODE_W] = msg_char(idx - 8);
      else          f[k*CODE_W +: CODE_W] = BLANK_CODE;
    end
    return f;
  endfunction

  msg_scroller_tick_gen #(.DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (cnt_en),
    .clr  (cnt_clr),
    .tick (tick)
  );

`ifdef SCROLL_HOLD_BLINK_EN
  logic blink_en, blink_tick, phase, phase_nxt;

  assign blink_en  = (state == ST_HOLD) && !bus.stop && bus.hold;
  assign phase_nxt = (state_nxt == ST_HOLD) ? (phase ^ blink_tick) : 1'b0;
  assign blank_sel = phase_nxt;

  msg_scroller_tick_gen #(.DIV(TICK_DIV)) u_blink_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (blink_en),
    .clr  (state != ST_HOLD),
    .tick (blink_tick)
  );

  // Blink phase: toggles on each blink tick in HOLD, cleared when leaving.
  always_ff @(posedge clk) begin
    if (rst) phase <= 1'b0;
    else     phase <= phase_nxt;
  end
`else
  assign blank_sel = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      pos   <= '0;
    end else begin
      state <= state_nxt;
      pos   <= pos_nxt;
    end
  end

  // Next-state, position and frame-update decisions; stop beats hold beats start.
  always_comb begin
    state_nxt = state;
    pos_nxt   = pos;
    upd       = 1'b0;
    cnt_en    = 1'b0;
    cnt_clr   = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        if (!bus.stop && bus.start) begin
          state_nxt = ST_SCROLL;
          pos_nxt   = '0;
          upd       = 1'b1;
        end
      end
      ST_SCROLL: begin
        if (bus.stop) begin
          state_nxt = ST_IDLE;
          pos_nxt   = '0;
          upd       = 1'b1;
        end else if (bus.hold) begin
          state_nxt = ST_HOLD;
        end else begin
          cnt_en = 1'b1;
          if (tick) begin
            pos_nxt = (pos == POS_LAST) ? '0 : pos + POS_W'(1);
            upd     = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (bus.stop) begin
          state_nxt = ST_IDLE;
          pos_nxt   = '0;
          upd       = 1'b1;
        end else if (!bus.hold) begin
          state_nxt = ST_SCROLL;
`ifdef SCROLL_HOLD_BLINK_EN
          if (phase) upd = 1'b1;
`endif
        end else begin
`ifdef SCROLL_HOLD_BLINK_EN
          if (blink_tick) upd = 1'b1;
`endif
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        pos_nxt   = '0;
        upd       = 1'b1;
      end
    endcase
  end

  // Registered display frame, built from the position being loaded.
  always_ff @(posedge clk) begin
    if (rst) begin
      digits    <= '1;
      frame_upd <= 1'b0;
    end else begin
      frame_upd <= upd;
      if (upd) digits <= blank_sel ? '1 : frame_at(pos_nxt);
    end
  end

  assign bus.digits    = digits;
  assign bus.frame_upd = frame_upd;
  assign bus.busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_msg_scroller.sv
// Directed bench for msg_scroller with TICK_DIV=4, MSG_LEN=8.
module tb_msg_scroller;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  msg_scroller_if bus ();

  msg_scroller #(.TICK_DIV(32'd4), .MSG_LEN(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Expected frame indexed by scroll position.
  logic [31:0] exp_tab [0:15] = '{
    32'hFFFF_FFFF, 32'hFFFF_FFF7, 32'hFFFF_FF76, 32'hFFFF_F765,
    32'hFFFF_7654, 32'hFFF7_6543, 32'hFF76_5432, 32'hF765_4321,
    32'h7654_3210, 32'h6543_210F, 32'h5432_10FF, 32'h4321_0FFF,
    32'h3210_FFFF, 32'h210F_FFFF, 32'h10FF_FFFF, 32'h0FFF_FFFF
  };

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_d;
    logic        exp_u;

    rst = 1'b1;
    bus.start = 1'b0;
    bus.hold  = 1'b0;
    bus.stop  = 1'b0;
    step();
    step();
    check("rst_digits", bus.digits, 32'hFFFF_FFFF);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_upd", {31'd0, bus.frame_upd}, 32'd0);
    rst = 1'b0;

    // Start, and keep start high through a full wrap: no restart expected.
    bus.start = 1'b1;
    step();
    check("start_busy", {31'd0, bus.busy}, 32'd1);
    check("start_upd", {31'd0, bus.frame_upd}, 32'd1);
    check("start_digits", bus.digits, 32'hFFFF_FFFF);
    for (int n = 1; n <= 16; n++) begin
      repeat (3) step();
      check("upd_between", {31'd0, bus.frame_upd}, 32'd0);
      step();
      check("scroll_digits", bus.digits, exp_tab[n % 16]);
      check("scroll_upd", {31'd0, bus.frame_upd}, 32'd1);
    end
    bus.start = 1'b0;

    // Continue to pos 5 after the wrap.
    for (int n = 1; n <= 5; n++) repeat (4) step();
    check("wrap_pos5", bus.digits, exp_tab[5]);

    // Move prescaler to 2, then hold for 20 cycles.
    step();
    step();
    bus.hold = 1'b1;
    for (int j = 0; j < 20; j++) begin
      step();
`ifdef SCROLL_HOLD_BLINK_EN
      exp_d = ((j >= 4 && j < 8) || (j >= 12 && j < 16)) ? 32'hFFFF_FFFF : exp_tab[5];
      exp_u = (j == 4 || j == 8 || j == 12 || j == 16);
`else
      exp_d = exp_tab[5];
      exp_u = 1'b0;
`endif
      check("hold_digits", bus.digits, exp_d);
      check("hold_upd", {31'd0, bus.frame_upd}, {31'd0, exp_u});
      check("hold_busy", {31'd0, bus.busy}, 32'd1);
    end
    bus.hold = 1'b0;
    step();
    check("release_upd0", {31'd0, bus.frame_upd}, 32'd0);
    check("release_digits", bus.digits, exp_tab[5]);
    step();
    check("release_upd1", {31'd0, bus.frame_upd}, 32'd0);
    step();
    check("resume_digits", bus.digits, exp_tab[6]);
    check("resume_upd", {31'd0, bus.frame_upd}, 32'd1);

    // stop, hold and start together.
    step();
    bus.stop  = 1'b1;
    bus.hold  = 1'b1;
    bus.start = 1'b1;
    step();
    check("stop_digits", bus.digits, 32'hFFFF_FFFF);
    check("stop_busy", {31'd0, bus.busy}, 32'd0);
    check("stop_upd", {31'd0, bus.frame_upd}, 32'd1);
    step();
    check("stop_idle_busy", {31'd0, bus.busy}, 32'd0);
    check("stop_idle_upd", {31'd0, bus.frame_upd}, 32'd0);
    bus.stop  = 1'b0;
    bus.hold  = 1'b0;
    bus.start = 1'b0;

    // Reset at pos 10 on the edge that would tick.
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (40) step();
    check("pre_rst_pos10", bus.digits, exp_tab[10]);
    repeat (3) step();
    rst = 1'b1;
    step();
    check("midrst_digits", bus.digits, 32'hFFFF_FFFF);
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check("midrst_upd", {31'd0, bus.frame_upd}, 32'd0);
    rst = 1'b0;
    step();
    check("post_rst_busy", {31'd0, bus.busy}, 32'd0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("restart_busy", {31'd0, bus.busy}, 32'd1);
    check("restart_upd", {31'd0, bus.frame_upd}, 32'd1);
    repeat (3) step();
    check("restart_no_tick", bus.digits, 32'hFFFF_FFFF);
    step();
    check("restart_first", bus.digits, exp_tab[1]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/msg_scroller.md
Name: msg_scroller

Overview:
- Upstream character source for the 8-digit multiplexed seven-segment driver.
- Holds a fixed message and scrolls it right-to-left across the 8 digit positions at a prescaled rate.
- Presents eight 4-bit character codes in parallel; the display driver decodes these codes (0..7 are message glyphs, 4'hF is blank).
- Control is start / hold / stop, driven by debounced board buttons.

Parameters:
- TICK_DIV, 25_000_000: clk cycles per scroll step; legal range 2..2^32-1.
- MSG_LEN, 8: number of message characters; legal range 1..56.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  level; in IDLE, begins scrolling.
- hold  input  1  level; while high in SCROLL/HOLD, freezes the frame.
- stop  input  1  level; returns to IDLE and blanks the display.
- digits  output  32  8 x 4-bit codes; [31:28] = leftmost digit 7, [3:0] = rightmost digit 0.
- frame_upd  output  1  one-cycle pulse in the cycle digits holds a new frame.
- busy  output  1  high in SCROLL or HOLD.

Behaviour:
- Stream: S = 8 blanks (4'hF) followed by MSG[0..MSG_LEN-1].
  - Stream length L = MSG_LEN+8.
  - Position register pos spans 0..L-1.
- Frame at pos p: digit k (k = 0..7) = S[(p + 7 - k) mod L].
  - p = 0 is an all-blank frame.
  - p = 1 puts MSG[0] on digit 0 only, so the message enters from the right.
- Prescaler cnt, 32-bit:
  - Counts 0..TICK_DIV-1 while in SCROLL; tick = (cnt == TICK_DIV-1).
  - Wraps to 0 on tick.
  - Cleared on entering SCROLL from IDLE.
  - Held, not cleared, in HOLD.
- States (registered encoding in package): IDLE, SCROLL, HOLD.
  - IDLE: start=1 & stop=0 -> SCROLL; pos=0, cnt=0.
  - SCROLL: stop=1 -> IDLE; else hold=1 -> HOLD; else on tick, pos <= (pos==L-1) ? 0 : pos+1. pos wraps continuously.
  - HOLD: stop=1 -> IDLE; else hold=0 -> SCROLL, cnt resumes from its held value.
  - Priority: rst > stop > hold > start > tick.
  - A tick coinciding with hold=1 is dropped; pos does not advance.
- digits is registered, computed from the next-pos value.
  - digits updates in the cycle after the tick edge.
  - frame_upd is high in that same cycle.
  - The SCROLL entry frame (all blank) also asserts frame_upd once.
- Entering IDLE via stop: digits <= 32'hFFFF_FFFF, pos <= 0, frame_upd pulses once.
- Reset values: state=IDLE, pos=0, cnt=0, digits=32'hFFFF_FFFF, frame_upd=0, busy=0.
  - Reset mid-scroll takes effect on the next edge regardless of any other input.
- start held high continuously in SCROLL has no effect; no restart occurs.

Optional Feature:
- Macro: SCROLL_HOLD_BLINK_EN.
- Defined:
  - In HOLD, a blink counter (same period TICK_DIV) toggles a phase bit.
  - Phase=1 drives digits to all-blank; phase=0 drives the frozen frame.
  - frame_upd pulses on each toggle.
  - Phase clears to 0 on leaving HOLD, and the frozen frame is restored the next cycle.
- Undefined: HOLD shows the static frozen frame; no blink logic is synthesised.

Decomposition:
- Package msg_scroller_pkg:
  - State encoding constants.
  - BLANK_CODE = 4'hF.
  - Message constant array MSG (default {7,6,5,4,3,2,1,0}).
  - Digit code width = 4.
- Sub-module tick_gen: parameterised prescaler with enable and clear, producing tick.
  - The same block is reused for the blink phase.

Test Plan:
- Reset: rst=1 for 2 cycles -> digits=FFFF_FFFF, busy=0, frame_upd=0.
- Start scroll (TICK_DIV=4, MSG_LEN=8): pulse start.
  - busy=1 on the next cycle.
  - First tick 4 cycles later.
  - One cycle after that: digits=FFFF_FFF7 with frame_upd=1.
  - After 8 ticks: digits=7654_3210.
- Wrap: continue to 16 ticks -> pos returns to 0, digits=FFFF_FFFF, scrolling continues.
- Hold mid-scroll: assert hold at pos=5 for 20 cycles.
  - digits is frozen and frame_upd stays 0.
  - On release, the next tick arrives within the remaining cnt cycles.
  - With SCROLL_HOLD_BLINK_EN: digits alternates frozen/blank every 4 cycles.
- Stop/hold/start together in SCROLL: stop=hold=start=1 -> IDLE, digits=FFFF_FFFF, busy=0.
- Reset mid-scroll at pos=10 with a tick in the same cycle: all state is at reset values on the next edge, and pos does not advance.
